// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Issue controller between decode and a single-cycle-registered
//               ALU. Accepts one decoded instruction at a time (valid/ready),
//               holds the ALU inputs stable for multi-cycle multiply/divide
//               ops, stalls on read-after-write hazards against the held op
//               and the pending writeback, and turns the ALU's always-on
//               write into a true register-file write strobe.
// Ports       : clk, reset (async, active-low), flush (sync kill)
//               in_*        : decoded instruction + valid/ready handshake
//               alu_*       : registered ALU inputs; alu_data/alu_dest_ret
//                             come back from the ALU
//               rf_raddr*   : register-file read addresses (= held rs1/rs2)
//               rf_wr_*     : gated register-file write port
//               busy        : op held or writeback pending
// Options     : `define ALU_ISSUE_PERF_EN adds perf_issued / perf_stall
//               counters of width CNT_W.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
`ifdef ALU_ISSUE_PERF_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [9:0]  in_opcode,
    input  logic [4:0]  in_regA,
    input  logic [11:0] in_regB,
    input  logic [4:0]  in_regDest,
    input  logic [19:0] in_uimm,
    output logic [4:0]  rf_raddrA,
    output logic [4:0]  rf_raddrB,
    output logic [9:0]  alu_opcode,
    output logic [4:0]  alu_regA,
    output logic [11:0] alu_regB,
    output logic [4:0]  alu_regDest,
    output logic [19:0] alu_uimm,
    input  logic [63:0] alu_data,
    input  logic [4:0]  alu_dest_ret,
    output logic        rf_wr_en,
    output logic [4:0]  rf_wr_addr,
    output logic [63:0] rf_wr_data,
    output logic        busy
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_issued,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    localparam logic [3:0] c_MUL_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] c_DIV_LAST = 4'(DIV_CYCLES - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_wb_pend;
    logic [4:0] r_wb_dest;

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    logic [6:0] w_op7;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_is_mext;
    logic       w_is_div;
    logic       w_is_mul;
    logic       w_use_rs2;
    logic [3:0] w_lat_last;

    assign w_op7 = in_opcode[6:0];
    assign w_f3  = in_opcode[9:7];
    assign w_f7  = in_regB[11:5];

    assign w_is_mext = (w_f7 == 7'b0000001) && ((w_op7 == 7'h33) || (w_op7 == 7'h3b));

    // The 64-bit R-type form uses funct3[2] to mark divide/remainder; the
    // 32-bit (W) form only treats the listed encodings as long-latency.
    assign w_is_div = w_is_mext &&
                      ((w_op7 == 7'h33) ? w_f3[2]
                                        : ((in_opcode == 10'h23b) ||
                                           (in_opcode == 10'h33b) ||
                                           (in_opcode == 10'h3bb)));
    assign w_is_mul = w_is_mext && !w_f3[2];

    // rs2 is a real register read only for R-type, branch and store.
    assign w_use_rs2 = (w_op7 == 7'h33) || (w_op7 == 7'h3b) ||
                       (w_op7 == 7'h63) || (w_op7 == 7'h23);

    always_comb begin
        w_lat_last = 4'd0;
        if (w_is_div) begin
            w_lat_last = c_DIV_LAST;
        end else if (w_is_mul) begin
            w_lat_last = c_MUL_LAST;
        end
    end

    // ------------------------------------------------------------------
    // Hazard detection and handshake
    // ------------------------------------------------------------------
    logic w_hold;
    logic w_hold_hit;
    logic w_wb_hit;
    logic w_hazard;
    logic w_accept;

    assign w_hold = (r_state == S_EXEC);

    // A held op on its last cycle still counts: its result is not yet in
    // the register file.
    assign w_hold_hit = w_hold && (alu_regDest != 5'd0) &&
                        ((in_regA == alu_regDest) ||
                         (w_use_rs2 && (in_regB[4:0] == alu_regDest)));
    assign w_wb_hit   = r_wb_pend && (r_wb_dest != 5'd0) &&
                        ((in_regA == r_wb_dest) ||
                         (w_use_rs2 && (in_regB[4:0] == r_wb_dest)));
    assign w_hazard   = w_hold_hit || w_wb_hit;

    assign in_ready = (!w_hold || (r_cnt == 4'd0)) && !w_hazard && !flush;
    assign w_accept = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Issue state, held ALU inputs and writeback flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_wb_pend   <= 1'b0;
            r_wb_dest   <= 5'd0;
            alu_opcode  <= 10'd0;
            alu_regA    <= 5'd0;
            alu_regB    <= 12'd0;
            alu_regDest <= 5'd0;
            alu_uimm    <= 20'd0;
        end else if (flush) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_wb_pend  <= 1'b0;
            alu_opcode <= 10'd0;
        end else begin
            // The ALU result of the last hold cycle appears one edge later.
            r_wb_pend <= w_hold && (r_cnt == 4'd0);
            if (w_hold && (r_cnt == 4'd0)) begin
                r_wb_dest <= alu_regDest;
            end

            if (w_accept) begin
                r_state     <= S_EXEC;
                r_cnt       <= w_lat_last;
                alu_opcode  <= in_opcode;
                alu_regA    <= in_regA;
                alu_regB    <= in_regB;
                alu_regDest <= in_regDest;
                alu_uimm    <= in_uimm;
            end else if (w_hold) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    // Opcode 0 is a no-op for the ALU.
                    r_state    <= S_IDLE;
                    alu_opcode <= 10'd0;
                end
            end
        end
    end

    assign rf_raddrA  = alu_regA;
    assign rf_raddrB  = alu_regB[4:0];
    assign rf_wr_addr = alu_dest_ret;
    assign rf_wr_data = alu_data;
    assign rf_wr_en   = r_wb_pend && !flush && (alu_dest_ret != 5'd0);
    assign busy       = w_hold || r_wb_pend;

`ifdef ALU_ISSUE_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters (wrap, unaffected by flush)
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_perf_issued;
    logic [CNT_W-1:0] r_perf_stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf_issued <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_accept) begin
                r_perf_issued <= r_perf_issued + CNT_W'(1);
            end
            if (in_valid && !in_ready) begin
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            end
        end
    end

    assign perf_issued = r_perf_issued;
    assign perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl. A table of isolated
//               instructions checks latency class, hold length, writeback
//               timing and data; hand-written sequences cover back-to-back
//               issue, hazards, flush and asynchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int MUL_CYCLES = 2;
    localparam int DIV_CYCLES = 8;
    localparam int CNT_W      = 32;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  in_opcode;
    logic [4:0]  in_regA;
    logic [11:0] in_regB;
    logic [4:0]  in_regDest;
    logic [19:0] in_uimm;
    logic [4:0]  rf_raddrA;
    logic [4:0]  rf_raddrB;
    logic [9:0]  alu_opcode;
    logic [4:0]  alu_regA;
    logic [11:0] alu_regB;
    logic [4:0]  alu_regDest;
    logic [19:0] alu_uimm;
    logic [63:0] alu_data;
    logic [4:0]  alu_dest_ret;
    logic        rf_wr_en;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    logic        busy;
`ifdef ALU_ISSUE_PERF_EN
    logic [CNT_W-1:0] perf_issued;
    logic [CNT_W-1:0] perf_stall;
`endif

    alu_issue_ctrl #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .CNT_W      (CNT_W)
`endif
    ) u_dut (
        .clk          (clk),
        .reset        (reset),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_regA      (in_regA),
        .in_regB      (in_regB),
        .in_regDest   (in_regDest),
        .in_uimm      (in_uimm),
        .rf_raddrA    (rf_raddrA),
        .rf_raddrB    (rf_raddrB),
        .alu_opcode   (alu_opcode),
        .alu_regA     (alu_regA),
        .alu_regB     (alu_regB),
        .alu_regDest  (alu_regDest),
        .alu_uimm     (alu_uimm),
        .alu_data     (alu_data),
        .alu_dest_ret (alu_dest_ret),
        .rf_wr_en     (rf_wr_en),
        .rf_wr_addr   (rf_wr_addr),
        .rf_wr_data   (rf_wr_data),
        .busy         (busy)
`ifdef ALU_ISSUE_PERF_EN
        ,
        .perf_issued  (perf_issued),
        .perf_stall   (perf_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Minimal registered ALU: result carries the destination and uimm so
    // that write data is predictable from the instruction alone.
    initial begin
        alu_data     = 64'd0;
        alu_dest_ret = 5'd0;
    end
    always @(posedge clk) begin
        alu_dest_ret <= alu_regDest;
        alu_data     <= {39'd0, alu_regDest, alu_uimm};
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: inputs are driven 2 time units after the rising edge and
    // outputs are sampled 1 unit later, well away from either edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [9:0] op, input logic [4:0] a,
                         input logic [11:0] b, input logic [4:0] rd, input logic [19:0] u);
        in_valid   = v;
        in_opcode  = op;
        in_regA    = a;
        in_regB    = b;
        in_regDest = rd;
        in_uimm    = u;
    endtask

    task automatic idle();
        drive(1'b0, 10'd0, 5'd0, 12'd0, 5'd0, 20'd0);
    endtask

    typedef struct {
        logic [9:0]  op;
        logic [4:0]  a;
        logic [11:0] b;
        logic [4:0]  rd;
        logic [19:0] u;
        int          lat;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // opcode, rs1, rs2/imm, rd, uimm, expected hold cycles
        vecs[0]  = '{10'h013, 5'd3, 12'h005, 5'd1,  20'h11111, 1};          // addi
        vecs[1]  = '{10'h033, 5'd3, 12'h004, 5'd2,  20'h22222, 1};          // add
        vecs[2]  = '{10'h033, 5'd3, 12'h404, 5'd3,  20'h33333, 1};          // sub
        vecs[3]  = '{10'h033, 5'd3, 12'h024, 5'd4,  20'h44444, MUL_CYCLES}; // mul
        vecs[4]  = '{10'h1B3, 5'd3, 12'h024, 5'd5,  20'h55555, MUL_CYCLES}; // mulhu
        vecs[5]  = '{10'h233, 5'd3, 12'h024, 5'd7,  20'h77777, DIV_CYCLES}; // div
        vecs[6]  = '{10'h3B3, 5'd3, 12'h024, 5'd8,  20'h88888, DIV_CYCLES}; // remu
        vecs[7]  = '{10'h23b, 5'd3, 12'h024, 5'd9,  20'h99999, DIV_CYCLES}; // divw
        vecs[8]  = '{10'h3bb, 5'd3, 12'h024, 5'd10, 20'hAAAAA, DIV_CYCLES}; // remuw
        vecs[9]  = '{10'h03b, 5'd3, 12'h024, 5'd11, 20'hBBBBB, MUL_CYCLES}; // mulw
        vecs[10] = '{10'h013, 5'd3, 12'h005, 5'd0,  20'hCCCCC, 1};          // addi x0
        vecs[11] = '{10'h013, 5'd3, 12'h024, 5'd12, 20'hDDDDD, 1};          // addi, imm looks like funct7=1
    end

    initial begin
        int held, wr_cnt, first_k;
        logic [4:0]  wr_addr;
        logic [63:0] wr_data;
        logic [4:0]  exp_addr [6];
        logic        exp_en   [6];

        reset = 1'b0;
        flush = 1'b0;
        idle();

        // ---------------- reset state ----------------
        repeat (3) cyc();
        #1;
        chk("rst_alu_opcode", 64'(alu_opcode), 64'd0);
        chk("rst_alu_fields", {alu_regA, alu_regB, alu_regDest, alu_uimm}, 64'd0);
        chk("rst_rf_wr_en", 64'(rf_wr_en), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;
        repeat (2) cyc();

        // ---------------- table: isolated instructions ----------------
        foreach (vecs[i]) begin
            idle();
            repeat (2) cyc();
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].u);
            #1;
            chk($sformatf("v%0d_ready", i), 64'(in_ready), 64'd1);
            held = 0; wr_cnt = 0; first_k = 0; wr_addr = 5'd0; wr_data = 64'd0;
            for (int k = 1; k <= 12; k++) begin
                cyc();
                idle();
                #1;
                if (k == 1)
                    chk($sformatf("v%0d_raddr", i), 64'({rf_raddrA, rf_raddrB}),
                        64'({vecs[i].a, vecs[i].b[4:0]}));
                if (alu_opcode == vecs[i].op && alu_regA == vecs[i].a &&
                    alu_regB == vecs[i].b && alu_regDest == vecs[i].rd &&
                    alu_uimm == vecs[i].u)
                    held++;
                if (rf_wr_en) begin
                    wr_cnt++;
                    if (wr_cnt == 1) begin
                        first_k = k;
                        wr_addr = rf_wr_addr;
                        wr_data = rf_wr_data;
                    end
                end
                if (k == vecs[i].lat + 2)
                    chk($sformatf("v%0d_busy_end", i), 64'(busy), 64'd0);
            end
            chk($sformatf("v%0d_hold_cycles", i), 64'(held), 64'(vecs[i].lat));
            chk($sformatf("v%0d_wr_count", i), 64'(wr_cnt), (vecs[i].rd != 5'd0) ? 64'd1 : 64'd0);
            if (vecs[i].rd != 5'd0) begin
                chk($sformatf("v%0d_wr_cycle", i), 64'(first_k), 64'(vecs[i].lat + 1));
                chk($sformatf("v%0d_wr_addr", i), 64'(wr_addr), 64'(vecs[i].rd));
                chk($sformatf("v%0d_wr_data", i), wr_data, {39'd0, vecs[i].rd, vecs[i].u});
            end
        end

        // ---------------- back-to-back addi x1,x2,x3 ----------------
        idle();
        repeat (2) cyc();
        exp_en   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_addr = '{5'd0, 5'd0, 5'd1, 5'd2, 5'd3, 5'd0};
        for (int c = 0; c < 6; c++) begin
            if (c > 0) cyc();
            if (c < 3) drive(1'b1, 10'h013, 5'(10 + c), 12'h001, 5'(1 + c), 20'(c));
            else       idle();
            #1;
            if (c < 3) chk($sformatf("b2b_ready_c%0d", c), 64'(in_ready), 64'd1);
            chk($sformatf("b2b_wr_en_c%0d", c), 64'(rf_wr_en), 64'(exp_en[c]));
            if (exp_en[c]) chk($sformatf("b2b_wr_addr_c%0d", c), 64'(rf_wr_addr), 64'(exp_addr[c]));
        end

        // ---------------- RAW hazard on x5 ----------------
        idle();
        repeat (3) cyc();
        drive(1'b1, 10'h033, 5'd1, 12'h002, 5'd5, 20'h00055);   // add x5
        #1;
        chk("haz_first_ready", 64'(in_ready), 64'd1);
        for (int c = 1; c <= 3; c++) begin
            cyc();
            drive(1'b1, 10'h013, 5'd5, 12'h001, 5'd6, 20'h00066); // addi x6, x5
            #1;
            chk($sformatf("haz_ready_c%0d", c), 64'(in_ready), (c == 3) ? 64'd1 : 64'd0);
            if (c == 2) chk("haz_x5_write", 64'({rf_wr_en, rf_wr_addr}), 64'({1'b1, 5'd5}));
        end
        cyc();
        idle();
        cyc();
        #1;
        chk("haz_x6_write", 64'({rf_wr_en, rf_wr_addr}), 64'({1'b1, 5'd6}));

        // ---------------- rs2 ignored for I-type ----------------
        idle();
        repeat (3) cyc();
        drive(1'b1, 10'h033, 5'd1, 12'h002, 5'd5, 20'h0);       // add x5
        cyc();
        drive(1'b1, 10'h013, 5'd3, 12'h005, 5'd8, 20'h0);       // addi x8, x3, 5
        #1;
        chk("itype_no_rs2_hazard", 64'(in_ready), 64'd1);
        cyc();
        drive(1'b1, 10'h033, 5'd3, 12'h008, 5'd9, 20'h0);       // add x9, x3, x8
        #1;
        chk("rtype_rs2_hazard", 64'(in_ready), 64'd0);

        // ---------------- flush during 4th cycle of div ----------------
        idle();
        repeat (4) cyc();
        drive(1'b1, 10'h233, 5'd3, 12'h024, 5'd7, 20'h00777);   // div x7
        #1;
        chk("flush_div_ready", 64'(in_ready), 64'd1);
        cyc(); idle();
        cyc();
        cyc();
        cyc();
        flush = 1'b1;
        drive(1'b1, 10'h013, 5'd1, 12'h001, 5'd13, 20'h0);      // ignored
        #1;
        chk("flush_ready_low", 64'(in_ready), 64'd0);
        chk("flush_busy_before", 64'(busy), 64'd1);
        cyc();
        flush = 1'b0;
        drive(1'b1, 10'h013, 5'd1, 12'h001, 5'd9, 20'h00999);   // addi x9
        #1;
        chk("flush_busy_after", 64'(busy), 64'd0);
        chk("flush_new_ready", 64'(in_ready), 64'd1);
        wr_cnt = 0;
        wr_addr = 5'd0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            idle();
            #1;
            if (rf_wr_en) begin
                wr_cnt++;
                wr_addr = rf_wr_addr;
            end
        end
        chk("flush_wr_count", 64'(wr_cnt), 64'd1);
        chk("flush_wr_addr", 64'(wr_addr), 64'd9);

        // ---------------- flush suppresses a pending write ----------------
        idle();
        repeat (3) cyc();
        drive(1'b1, 10'h013, 5'd1, 12'h001, 5'd4, 20'h0);       // addi x4
        cyc(); idle();
        cyc();
        flush = 1'b1;
        #1;
        chk("flush_wb_suppressed", 64'(rf_wr_en), 64'd0);
        cyc();
        flush = 1'b0;
        #1;
        chk("flush_wb_cleared", 64'({busy, rf_wr_en}), 64'd0);

        // ---------------- async reset mid-mul ----------------
        idle();
        repeat (3) cyc();
        drive(1'b1, 10'h033, 5'd1, 12'h022, 5'd6, 20'h00AAA);   // mul x6
        cyc();
        idle();
        #1;
        chk("mul_held_before_reset", 64'(alu_opcode), 64'h033);
        reset = 1'b0;
        #1;
        chk("reset_alu_opcode", 64'(alu_opcode), 64'd0);
        chk("reset_alu_fields", {alu_regA, alu_regB, alu_regDest, alu_uimm}, 64'd0);
        chk("reset_raddr", 64'({rf_raddrA, rf_raddrB}), 64'd0);
        chk("reset_busy_wr", 64'({busy, rf_wr_en}), 64'd0);
`ifdef ALU_ISSUE_PERF_EN
        chk("reset_perf_issued", 64'(perf_issued), 64'd0);
        chk("reset_perf_stall", 64'(perf_stall), 64'd0);
`endif
        cyc();
        cyc();
        reset = 1'b1;
        wr_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            #1;
            if (rf_wr_en) wr_cnt++;
        end
        chk("reset_no_write", 64'(wr_cnt), 64'd0);
        chk("reset_idle_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Issue controller in front of the single-cycle-registered ALU.
- Accepts one decoded instruction at a time via valid/ready.
- Drives the ALU operand/opcode inputs and holds them stable for the required number of cycles for multiply/divide ops.
- Stalls on register read-after-write hazards.
- Gates the ALU's always-on wr_en into a true register-file write strobe.
- Sits between decode and the ALU/register-file write port.

Parameters:
MUL_CYCLES, 2, cycles ALU inputs are held for M-extension multiply ops (funct7 = 0000001, funct3 0..3). Legal range 1..15.
DIV_CYCLES, 8, cycles held for divide/remainder ops (funct7 = 0000001, funct3 4..7, and opcodes 0x23b/0x33b/0x3bb). Legal range 1..15.
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous kill of the held op and any pending writeback
in_valid  in  1  decoded instruction valid
in_ready  out  1  controller accepts this cycle
in_opcode  in  10  {funct3, opcode[6:0]}
in_regA  in  5  rs1
in_regB  in  12  rs2/immediate field (rs2 = [4:0], funct7 = [11:5])
in_regDest  in  5  rd
in_uimm  in  20  U-type immediate
rf_raddrA  out  5  register-file read address A (= alu_regA)
rf_raddrB  out  5  register-file read address B (= alu_regB[4:0])
alu_opcode  out  10  to ALU opcode
alu_regA  out  5  to ALU regA
alu_regB  out  12  to ALU regB
alu_regDest  out  5  to ALU regDest
alu_uimm  out  20  to ALU uimm
alu_data  in  64  ALU data_out
alu_dest_ret  in  5  ALU aluRegDest
rf_wr_en  out  1  gated register-file write enable
rf_wr_addr  out  5  write address
rf_wr_data  out  64  write data
busy  out  1  op held or writeback pending

Behaviour:
- Reset (reset = 0, asynchronous): hold_valid = 0, wb_pend = 0, cnt = 0; all alu_* outputs = 0 (opcode 0 is a no-op for the ALU); rf_wr_en = 0; busy = 0.
- Latency class at accept: lat = DIV_CYCLES for div/rem, MUL_CYCLES for multiply, otherwise 1.
- States:
  - IDLE (hold_valid = 0).
  - EXEC (hold_valid = 1, cnt counts lat-1 down to 0).
  - The WB flag is pipelined separately (wb_pend).
- Accept: in_valid & in_ready at edge T → alu_* = captured fields from T+1; cnt = lat-1.
- EXEC:
  - cnt > 0: decrement cnt and hold alu_* stable.
  - cnt = 0 (last hold cycle): wb_pend is set at the next edge, with wb_dest = held regDest.
- Writeback: while wb_pend = 1, rf_wr_en = 1 and wb_pend clears the following edge.
  - rf_wr_addr = alu_dest_ret and rf_wr_data = alu_data.
  - A single-cycle op accepted at T writes at cycle T+2.
  - rf_wr_en is forced to 0 when rf_wr_addr = 0.
- in_ready = (!hold_valid | cnt == 0) & !hazard & !flush. This allows back-to-back single-cycle issue.
- hazard = rs1 or rs2 (rs2 only for opcode[6:0] = 0x33/0x3b, or branch/store) equals a nonzero rd of (a) the held op or (b) the pending writeback.
  - A held op with cnt = 0 still counts toward the hazard.
- When not accepting and cnt = 0: hold_valid clears and alu_opcode is forced to 0.
- flush:
  - Clears hold_valid and wb_pend at the next edge.
  - Suppresses rf_wr_en in the same cycle.
  - in_valid is ignored that cycle.
- Reset asserted mid-EXEC: the op is discarded and no write occurs.
- busy = hold_valid | wb_pend.

Optional Feature:
ALU_ISSUE_PERF_EN
- Defined: adds outputs perf_issued [CNT_W] (accepted ops) and perf_stall [CNT_W] (cycles with in_valid & !in_ready).
  - Both counters are async-cleared by reset and wrap modulo 2^CNT_W.
  - Both are unaffected by flush.
- Undefined: these ports and counters do not exist.

Test Plan:
- Three back-to-back addi (rd = 1, 2, 3) with independent sources → in_ready stays 1; rf_wr_en pulses at T+2, T+3, T+4 with addrs 1, 2, 3.
- add x5 accepted at T, next op reads x5 → in_ready = 0 for 2 cycles; second op is accepted at T+3.
- div x7 (opcode 0x233, funct7 = 1) with DIV_CYCLES = 8 → alu_* stable for 8 cycles; a single rf_wr_en pulse at T+9 to x7.
- addi with rd = x0 → no rf_wr_en pulse; busy deasserts at T+3.
- flush during the 4th cycle of a div → no write; busy = 0 the next cycle; a new op is accepted the following cycle.
- reset pulled low mid-mul → all outputs 0 immediately; with ALU_ISSUE_PERF_EN defined, perf counters read 0.
